// File: rtl/nibble_serial_pkg.sv
// nibble_serial_pkg: shared state encoding and slice width for the nibble-serial adder
package nibble_serial_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_fa.sv
// four_bit_FA: purely combinational 4-bit adder with carry in/out
module four_bit_FA (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide add through one shared 4-bit adder, one nibble per clock, LSB nibble first
module nibble_serial_adder_ctrl
  import nibble_serial_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    c_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                    c_out,
  output logic                    busy
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  state_t state, state_nx;
  logic [W-1:0] a_sh, b_sh;
  logic [W+NIBBLE_W-1:0] sum_sh;
  logic [NIBBLE_W-1:0] fa_sum;
  logic [IW-1:0] idx;
  logic carry, fa_co, accept, last;
  four_bit_FA u_fa (
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .c_in (carry),
    .sum  (fa_sum),
    .c_out(fa_co)
  );
  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign busy      = state == ST_RUN || state == ST_DONE;
  assign accept    = in_ready && in_valid;
  assign last      = idx == IW'(NIBBLES - 1);
  // new nibble enters at the top so the LSB nibble ends up at the bottom after NIBBLES shifts
  assign sum_sh    = {fa_sum, sum};
  always_comb
    state_nx = state == ST_IDLE ? (in_valid ? ST_RUN : ST_IDLE) :
               state == ST_RUN  ? (last ? ST_DONE : ST_RUN) :
               state == ST_DONE ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= c_in;
      idx   <= '0;
      sum   <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> NIBBLE_W;
      b_sh  <= b_sh >> NIBBLE_W;
      sum   <= sum_sh[W+NIBBLE_W-1:NIBBLE_W];
      carry <= fa_co;
      idx   <= idx + IW'(1);
      if (last) c_out <= fa_co;
    end
endmodule
